pc_gen: RTL
===========

Name: pc_gen

Overview:
- PRE_IF program-counter generator and the consumer of the 3-bit PC-select code.
- Holds the architectural fetch PC and computes the next PC from the select code and the candidate targets.
- Presents the PC to the IF stage with a valid/ready handshake.
- Buffers a redirect that arrives while IF is stalled, so no redirect is lost.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.
- PC_W, 32, PC and target width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- pc_sel  in  3  next-PC select code: 000 PC4, 001 ImmeJump, 010 EPC, 011 Except, 100 Branch, 101 JR, 110 MEMPC, 111 invalid
- imme_jump_target  in  PC_W  J/JAL target
- branch_target  in  PC_W  resolved conditional-branch target
- jr_target  in  PC_W  JR/JALR register target
- epc  in  PC_W  CP0 EPC (ERET return)
- except_vec  in  PC_W  exception entry vector
- mem_pc  in  PC_W  refetch PC
- if_ready  in  1  IF accepts the current PC this cycle
- pc_valid  out  1  pc is valid for fetch
- pc  out  PC_W  current fetch PC
- redirect_pending  out  1  buffered redirect not yet applied
- redirect_taken  out  1  one-cycle pulse: pc was loaded from a redirect target in the previous edge
- fetch_adel  out  1  pc[1:0] != 0 (optional feature)

Behaviour:
- Reset (resetn=0 at posedge): pc=RESET_PC, pc_valid=0, redirect_pending=0, redirect_taken=0, fetch_adel=0. Reset overrides every other input, including a redirect arriving in the same cycle.
- First posedge with resetn=1: pc_valid becomes 1 and stays 1 until the next reset. pc is unchanged on that edge.
- Handshake: fire = pc_valid & if_ready. pc holds stable while !fire.
- Redirect class (from pc_sel):
  - class 2 (exception): EPC, Except, MEMPC.
  - class 1 (control): ImmeJump, Branch, JR.
  - class 0: PC4.
  - Code 111 is treated as class 0. The simulation assertion flags it as an error.
- Incoming redirect (class > 0) in cycle t:
  - If fire: pc at t+1 = selected target, redirect_taken=1 at t+1.
  - If !fire: latch the target and class into the pending buffer; redirect_pending=1 at t+1.
- Buffer overwrite rule: an incoming redirect replaces a pending one only if incoming class >= pending class. Otherwise it is dropped, so an exception is never displaced by a younger branch.
- Buffered redirect: on the next fire, pc <= pending target; redirect_pending clears and redirect_taken pulses.
  - If an incoming redirect arrives in that same fire cycle, the overwrite rule picks the winner and the buffer clears.
- No redirect and no pending on fire: pc <= pc + 4. Arithmetic is modulo 2^PC_W; wrap from 32'hFFFF_FFFC to 0 is legal.
- Targets are sampled only in the cycle their select code is asserted; later changes to target inputs do not affect a latched redirect.
- Latency: redirect to pc update is 1 cycle when if_ready; otherwise the first fire edge after the redirect.

Optional Feature:
- Macro: PCGEN_ALIGN_CHECK_EN.
- Defined: fetch_adel = pc_valid & (pc[1:0] != 0), registered alongside pc. pc still advances normally; the exception is raised downstream.
- Undefined: fetch_adel tied to 0 and no alignment logic is present.

Decomposition:
- Shared CPU package holds:
  - pc_sel_t enum with the eight codes above.
  - the redirect-class encoding.
  - RESET_PC default.
  - These replace the per-module select-code parameters.
- Sub-module pc_redirect_buf: the pending target/class register with the overwrite-by-priority rule. pc_gen instantiates it once.

Test Plan:
- Reset, then if_ready=1 for 3 cycles -> pc_valid=0 during reset; pc sequence BFC00000, BFC00000 (first valid cycle), BFC00004, BFC00008.
- pc_sel=100, branch_target=8000_0100, if_ready=1 -> next pc=8000_0100, redirect_taken pulses 1 cycle, then 8000_0104.
- if_ready=0, pc_sel=101 with jr_target=8000_0200, hold 3 cycles with pc_sel=000 -> pc unchanged, redirect_pending=1. Then if_ready=1 -> pc=8000_0200, pending cleared.
- if_ready=0:
  - pc_sel=011 with except_vec=BFC0_0380.
  - Next cycle pc_sel=100 with branch_target=8000_0300.
  - Then if_ready=1.
  - Expected: pc=BFC0_0380 (branch dropped).
- Pending branch to 8000_0400, then fire cycle with pc_sel=110 and mem_pc=8000_0010 -> pc=8000_0010.
- resetn=0 during a pending redirect -> pc=BFC0_0000, pending=0. With PCGEN_ALIGN_CHECK_EN, jr_target=8000_0002 -> fetch_adel=1 with pc=8000_0002.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared CPU front-end definitions: PC-select codes, redirect classes and reset PC.
package pc_gen_pkg;

    localparam int unsigned PC_W_DEF     = 32;
    localparam int unsigned SEL_W        = 3;
    localparam int unsigned CLS_W        = 2;
    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

    typedef enum logic [SEL_W-1:0] {
        PC_SEL_PC4     = 3'b000,
        PC_SEL_IMME    = 3'b001,
        PC_SEL_EPC     = 3'b010,
        PC_SEL_EXCEPT  = 3'b011,
        PC_SEL_BRANCH  = 3'b100,
        PC_SEL_JR      = 3'b101,
        PC_SEL_MEMPC   = 3'b110,
        PC_SEL_INVALID = 3'b111
    } pc_sel_t;

    // Higher class wins; exceptions must never be displaced by control flow.
    typedef enum logic [CLS_W-1:0] {
        RD_NONE = 2'd0,
        RD_CTRL = 2'd1,
        RD_EXC  = 2'd2
    } rd_class_t;

    function automatic rd_class_t sel_class(input pc_sel_t sel);
        rd_class_t cls;
        cls = RD_NONE;
        case (sel)
            PC_SEL_EPC, PC_SEL_EXCEPT, PC_SEL_MEMPC: cls = RD_EXC;
            PC_SEL_IMME, PC_SEL_BRANCH, PC_SEL_JR:   cls = RD_CTRL;
            default:                                 cls = RD_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-PC handshake between the PC generator (master) and the IF stage (slave).
interface pc_gen_if #(
    parameter int unsigned PC_W = 32
);
    logic            pc_valid;
    logic [PC_W-1:0] pc;
    logic            if_ready;
    logic            fetch_adel;

    modport master (output pc_valid, output pc, output fetch_adel, input if_ready);
    modport slave  (input pc_valid, input pc, input fetch_adel, output if_ready);
endinterface

// File: rtl/pc_gen_redirect_buf.sv
// Pending-redirect register; a new redirect replaces the held one only at equal or higher class.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            fire,
    input  rd_class_t       in_class,
    input  logic [PC_W-1:0] in_target,
    output logic            pend_valid,
    output logic            win_valid_c,
    output logic [PC_W-1:0] win_target_c
);

    logic            valid_q,  valid_d;
    rd_class_t       class_q,  class_d;
    logic [PC_W-1:0] target_q, target_d;
    logic            take_in;
    rd_class_t       win_class;

    always_comb begin
        take_in      = (in_class != RD_NONE) && (!valid_q || (in_class >= class_q));
        win_valid_c  = take_in || valid_q;
        win_target_c = take_in ? in_target : target_q;
        win_class    = take_in ? in_class  : class_q;

        valid_d  = valid_q;
        class_d  = class_q;
        target_d = target_q;
        // A fire consumes whichever redirect won, so the buffer always empties then.
        if (fire) begin
            valid_d = 1'b0;
            class_d = RD_NONE;
        end else if (win_valid_c) begin
            valid_d  = 1'b1;
            class_d  = win_class;
            target_d = win_target_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q  <= 1'b0;
            class_q  <= RD_NONE;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            class_q  <= class_d;
            target_q <= target_d;
        end
    end

    assign pend_valid = valid_q;

endmodule

// File: rtl/pc_gen.sv
// PRE_IF fetch-PC generator with stall-safe redirect buffering.
// Optional fetch alignment check enabled by defining PCGEN_ALIGN_CHECK_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [2:0]      pc_sel,
    input  logic [PC_W-1:0] imme_jump_target,
    input  logic [PC_W-1:0] branch_target,
    input  logic [PC_W-1:0] jr_target,
    input  logic [PC_W-1:0] epc,
    input  logic [PC_W-1:0] except_vec,
    input  logic [PC_W-1:0] mem_pc,
    pc_gen_if.master        fetch_if,
    output logic            redirect_pending,
    output logic            redirect_taken
);

    pc_sel_t         sel;
    rd_class_t       in_class;
    logic [PC_W-1:0] in_target;
    logic            fire_c;
    logic            win_valid_c;
    logic [PC_W-1:0] win_target_c;

    logic            pc_valid_q, pc_valid_d;
    logic [PC_W-1:0] pc_q,       pc_d;
    logic            taken_q,    taken_d;

    // Targets are sampled only in the cycle their select code is presented.
    always_comb begin
        sel      = pc_sel_t'(pc_sel);
        in_class = sel_class(sel);
        case (sel)
            PC_SEL_IMME:   in_target = imme_jump_target;
            PC_SEL_EPC:    in_target = epc;
            PC_SEL_EXCEPT: in_target = except_vec;
            PC_SEL_BRANCH: in_target = branch_target;
            PC_SEL_JR:     in_target = jr_target;
            PC_SEL_MEMPC:  in_target = mem_pc;
            default:       in_target = '0;
        endcase
    end

    pc_redirect_buf #(.PC_W(PC_W)) u_redirect_buf (
        .clk          (clk),
        .resetn       (resetn),
        .fire         (fire_c),
        .in_class     (in_class),
        .in_target    (in_target),
        .pend_valid   (redirect_pending),
        .win_valid_c  (win_valid_c),
        .win_target_c (win_target_c)
    );

    always_comb begin
        fire_c     = pc_valid_q && fetch_if.if_ready;
        pc_valid_d = 1'b1;
        pc_d       = pc_q;
        taken_d    = 1'b0;
        if (fire_c) begin
            taken_d = win_valid_c;
            pc_d    = win_valid_c ? win_target_c : pc_q + PC_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_valid_q <= 1'b0;
            pc_q       <= RESET_PC;
            taken_q    <= 1'b0;
        end else begin
            pc_valid_q <= pc_valid_d;
            pc_q       <= pc_d;
            taken_q    <= taken_d;
        end
    end

`ifdef PCGEN_ALIGN_CHECK_EN
    logic adel_q, adel_d;

    always_comb begin
        adel_d = pc_valid_d && (pc_d[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (!resetn) adel_q <= 1'b0;
        else         adel_q <= adel_d;
    end

    assign fetch_if.fetch_adel = adel_q;
`else
    assign fetch_if.fetch_adel = 1'b0;
`endif

    assign fetch_if.pc_valid = pc_valid_q;
    assign fetch_if.pc       = pc_q;
    assign redirect_taken    = taken_q;

    // Code 111 has no defined target; it falls back to sequential fetch.
    always @(posedge clk) begin
        if (resetn) begin
            assert (pc_sel != 3'b111) else $error("pc_gen: invalid pc_sel code 3'b111");
        end
    end

endmodule
